// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: owns the PC, issues one sequential imem read per cycle into a FIFO,
// and hands instructions to the decoder via valid/ready. Optional counters under FETCH_PREFETCH_STATS_EN.
module fetch_prefetch_queue #(
    parameter int instr_width = 9,
    parameter int pc_width    = 9,
    parameter int depth       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [pc_width-1:0]    start_addr,
    input  logic                   branch,
    input  logic [pc_width-1:0]    target,
    input  logic                   halt,
    output logic [pc_width-1:0]    imem_addr,
    output logic                   imem_req,
    input  logic [instr_width-1:0] imem_data,
    output logic [instr_width-1:0] instr_out,
    output logic [pc_width-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
`ifdef FETCH_PREFETCH_STATS_EN
    output logic [15:0]            flush_drops,
    output logic [15:0]            fetch_stalls,
`endif
    output logic [1:0]             fetch_state
);
    localparam int aw = $clog2(depth);
    localparam logic [aw+1:0] depth_c = (aw + 2)'(depth);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [pc_width-1:0]    pc_q;
    logic [pc_width-1:0]    req_pc_q;
    logic                   inflight_q;
    logic [aw-1:0]          rd_ptr_q, wr_ptr_q;
    logic [aw:0]            count_q;
    logic [instr_width-1:0] data_mem [depth];
    logic [pc_width-1:0]    pc_mem   [depth];

    logic run, kill, credit, push, pop;

    // kill covers every event that discards queued and in-flight work: start, or branch/halt while running.
    always_comb begin
        run         = (state_q == RUN);
        kill        = start || (run && (halt || branch));
        credit      = ({1'b0, count_q} + (aw + 2)'(inflight_q)) < depth_c;
        imem_req    = run && !kill && credit;
        imem_addr   = pc_q;
        instr_valid = run && (count_q != '0);
        push        = inflight_q && !kill;
        pop         = instr_valid && instr_ready && !kill;
        instr_out   = instr_valid ? data_mem[rd_ptr_q] : '0;
        instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : '0;
        fetch_state = state_q;
    end

    always_comb begin
        state_d = state_q;
        if (start)
            state_d = RUN;
        else if (run && halt)
            state_d = HALTED;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= imem_req;
            if (imem_req)
                req_pc_q <= pc_q;

            if (start)
                pc_q <= start_addr;
            else if (run && branch && !halt)
                pc_q <= target;
            else if (imem_req)
                pc_q <= pc_q + 1'b1;

            if (kill) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; outputs are masked by instr_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_data;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

`ifdef FETCH_PREFETCH_STATS_EN
    logic [16:0] drops_sum;
    logic        stall_cycle;

    always_comb begin
        drops_sum   = {1'b0, flush_drops} + 17'(count_q) + 17'(inflight_q);
        stall_cycle = run && !imem_req && !start && !(branch && !halt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_drops  <= '0;
            fetch_stalls <= '0;
        end else if (start) begin
            flush_drops  <= '0;
            fetch_stalls <= '0;
        end else begin
            if (kill)
                flush_drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
            if (stall_cycle && fetch_stalls != 16'hFFFF)
                fetch_stalls <= fetch_stalls + 16'd1;
        end
    end
`endif

endmodule
